// File: rtl/bbpu_bus_sched_pkg.sv
// Shared definitions for the BBPU pad bus scheduler.
// FSM encoding and elaboration-time parameter checks.
package bbpu_bus_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_TURN,
    S_SAMPLE,
    S_FIN
  } sched_state_e;

  function automatic bit sched_params_ok(
    input int nreq,
    input int dw,
    input int bit_cyc,
    input int ta_cyc
  );
    return (nreq >= 2) && (dw >= 2) &&
           (bit_cyc >= 4) && (bit_cyc % 2 == 0) &&
           (ta_cyc >= 1);
  endfunction

endpackage

// File: rtl/bbpu_rr_arb.sv
// Combinational round-robin pick: first set request
// at or after the pointer, wrapping; one-hot result.
module bbpu_rr_arb #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   win
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        win      = PW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bbpu_bus_sched.sv
// Round-robin owner of a shared pull-up pad: serialises a
// write word MSB first, optionally turns around and reads back.
module bbpu_bus_sched
  import bbpu_bus_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int BIT_CYC = 4,
  parameter int TA_CYC  = 2
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [NREQ-1:0]  REQ,
  input  logic [NREQ-1:0]  RD,
  input  logic [NREQ*DW-1:0] WDATA,
  output logic [NREQ-1:0]  GNT,
  output logic             BUSY,
  output logic             DONE,
  output logic [DW-1:0]    RDATA,
  output logic             PAD_I,
  output logic             PAD_T,
  input  logic             PAD_O
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(DW + 1);
  localparam int CW = $clog2(BIT_CYC);
  localparam int TW = $clog2(TA_CYC + 1);

  if (!sched_params_ok(NREQ, DW, BIT_CYC, TA_CYC)) begin : g_bad_cfg
    $error("bbpu_bus_sched: parameter out of range");
  end

  sched_state_e    state_q, state_d;
  logic [PW-1:0]   ptr_q, win_q, arb_win;
  logic [NREQ-1:0] arb_gnt;
  logic            rd_q;
  logic [DW-1:0]   wsh_q, wsh_d;
  logic [DW-1:0]   rsh_q, rsh_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [TW-1:0]   ta_q, ta_d;
  logic [1:0]      sync_q;
  logic            bit_end, last_bit, grant;

  bbpu_rr_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req  (REQ),
    .ptr  (ptr_q),
    .gnt  (arb_gnt),
    .win  (arb_win)
  );

  assign BUSY  = (state_q != S_IDLE);
  assign grant = (state_q == S_IDLE) && (|arb_gnt);

  always_comb begin
    state_d  = state_q;
    wsh_d    = wsh_q;
    rsh_d    = rsh_q;
    bit_d    = bit_q;
    cyc_d    = cyc_q;
    ta_d     = ta_q;
    bit_end  = (cyc_q == CW'(BIT_CYC - 1));
    last_bit = (bit_q == BW'(DW - 1));
    unique case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_DRIVE;
          wsh_d   = WDATA[arb_win*DW +: DW];
          bit_d   = '0;
          cyc_d   = '0;
        end
      end
      S_DRIVE: begin
        cyc_d = bit_end ? '0 : cyc_q + 1'b1;
        if (bit_end) begin
          wsh_d = {wsh_q[DW-2:0], 1'b0};
          if (last_bit) begin
            state_d = rd_q ? S_TURN : S_FIN;
            bit_d   = '0;
            ta_d    = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_TURN: begin
        if (ta_q == TW'(TA_CYC - 1)) begin
          state_d = S_SAMPLE;
          cyc_d   = '0;
          bit_d   = '0;
        end else begin
          ta_d = ta_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        cyc_d = bit_end ? '0 : cyc_q + 1'b1;
        // mid-bit sample keeps clear of the driver's bit edges
        if (cyc_q == CW'(BIT_CYC / 2))
          rsh_d = {rsh_q[DW-2:0], sync_q[1]};
        if (bit_end) begin
          if (last_bit) state_d = S_FIN;
          else          bit_d   = bit_q + 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      rd_q    <= 1'b0;
      wsh_q   <= '0;
      rsh_q   <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      ta_q    <= '0;
      sync_q  <= 2'b11;
      GNT     <= '0;
      DONE    <= 1'b0;
      RDATA   <= '0;
      PAD_I   <= 1'b1;
      PAD_T   <= 1'b1;
    end else begin
      state_q <= state_d;
      wsh_q   <= wsh_d;
      rsh_q   <= rsh_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      ta_q    <= ta_d;
      sync_q  <= {sync_q[0], PAD_O};
      PAD_T   <= (state_d != S_DRIVE);
      PAD_I   <= (state_d == S_DRIVE) ? wsh_d[DW-1] : 1'b1;
      DONE    <= (state_d == S_FIN);
      if (grant) begin
        GNT   <= arb_gnt;
        win_q <= arb_win;
        rd_q  <= RD[arb_win];
      end
      if (state_q == S_FIN) begin
        GNT   <= '0;
        ptr_q <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
      end
      if (state_d == S_FIN && rd_q)
        RDATA <= rsh_d;
    end
  end

endmodule

// File: tb/tb_bbpu_bus_sched.sv
// Scoreboard bench for bbpu_bus_sched with a pull-up pad
// and a per-requester read-back device model.
module tb_bbpu_bus_sched;

  localparam int NREQ     = 4;
  localparam int DW       = 8;
  localparam int BIT_CYC  = 4;
  localparam int TA_CYC   = 2;
  localparam int WR_LAT   = DW * BIT_CYC;
  localparam int RD_START = DW * BIT_CYC + TA_CYC;
  localparam int RD_LAT   = 2 * DW * BIT_CYC + TA_CYC;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] rd = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic [NREQ-1:0] gnt;
  logic            busy, done;
  logic [DW-1:0]   rdata;
  logic            pad_i, pad_t, pad_o;

  always #5 clk = ~clk;

  bbpu_bus_sched #(
    .NREQ    (NREQ),
    .DW      (DW),
    .BIT_CYC (BIT_CYC),
    .TA_CYC  (TA_CYC)
  ) dut (
    .CLK   (clk),
    .RSTN  (rstn),
    .REQ   (req),
    .RD    (rd),
    .WDATA (wdata),
    .GNT   (gnt),
    .BUSY  (busy),
    .DONE  (done),
    .RDATA (rdata),
    .PAD_I (pad_i),
    .PAD_T (pad_t),
    .PAD_O (pad_o)
  );

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [DW-1:0]   wd;
    logic [DW-1:0]   rdata;
    int              lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [DW-1:0] dev_data [NREQ];
  logic [NREQ-1:0] dev_en = '0;
  int          ptr_m = 0;
  logic [DW-1:0] last_rd = '0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Pad line: DUT drives when PAD_T=0, else the device of the
  // granted requester (if enabled) drives its word in the read
  // window, otherwise the pull-up holds the line high.
  int   dev_c = -1;
  logic dev_bit = 1'b1;

  always @(negedge clk) begin
    if (gnt == '0) dev_c = -1;
    else           dev_c = dev_c + 1;
    dev_bit = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i] && dev_en[i] &&
          dev_c >= RD_START && dev_c < RD_START + DW * BIT_CYC)
        dev_bit = dev_data[i][DW-1-(dev_c-RD_START)/BIT_CYC];
    end
  end

  assign pad_o = pad_t ? dev_bit : pad_i;

  // Monitor
  int            mc = -1;
  int            low_n = 0;
  int            hi_run = 0;
  bit            seen_drv = 1'b0;
  logic          prev_t = 1'b1;
  logic [DW-1:0] wcap = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      mc = -1; low_n = 0; hi_run = 0;
      seen_drv = 1'b0; prev_t = 1'b1; wcap = '0;
    end else begin
      check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
      if (gnt == '0) begin
        mc = -1; low_n = 0; wcap = '0;
        check("pad_t_ungranted", 32'(pad_t), 32'd1);
      end else begin
        mc++;
        if (!pad_t) low_n++;
        if (mc < WR_LAT && mc % BIT_CYC == BIT_CYC / 2)
          wcap = {wcap[DW-2:0], pad_i};
      end
      if (!pad_t) begin
        if (prev_t && seen_drv)
          check("drive_gap", 32'(hi_run >= 2), 32'd1);
        seen_drv = 1'b1;
        hi_run = 0;
      end else begin
        hi_run++;
      end
      prev_t = pad_t;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got DONE gnt=%b, want none", gnt);
        end else begin
          e = exp_q.pop_front();
          check("gnt", 32'(gnt), 32'(e.gnt));
          check("latency", 32'(mc), 32'(e.lat));
          check("pad_i_serial", 32'(wcap), 32'(e.wd));
          check("drive_len", 32'(low_n), 32'(WR_LAT));
          check("rdata", 32'(rdata), 32'(e.rdata));
        end
      end
    end
  end

  // Reference: serve the raised set in round-robin order.
  task automatic issue_batch(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] left;
    exp_t e;
    int w;
    left = mask;
    while (left != '0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && left[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
      e.gnt = '0;
      e.gnt[w] = 1'b1;
      e.wd = wdata[w*DW +: DW];
      if (rd[w]) begin
        last_rd = dev_en[w] ? dev_data[w] : {DW{1'b1}};
        e.lat = RD_LAT;
      end else begin
        e.lat = WR_LAT;
      end
      e.rdata = last_rd;
      exp_q.push_back(e);
      left[w] = 1'b0;
      ptr_m = (w + 1) % NREQ;
    end
    req = mask;
  endtask

  task automatic wait_batch(input bit scramble);
    int budget;
    bit ok;
    budget = 3000;
    ok = 1'b0;
    while (budget > 0 && !ok) begin
      @(negedge clk);
      budget--;
      if (done) begin
        req = req & ~gnt;
      end else if (scramble) begin
        for (int i = 0; i < NREQ; i++) begin
          if (gnt[i]) begin
            wdata[i*DW +: DW] = DW'($urandom);
            rd[i] = 1'($urandom);
            if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
          end
        end
      end
      if (req == '0 && exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL batch_timeout: got %0d pending, want 0", exp_q.size());
      exp_q.delete();
      req = '0;
    end
  endtask

  task automatic randomise_slots();
    for (int i = 0; i < NREQ; i++) begin
      wdata[i*DW +: DW] = DW'($urandom);
      rd[i] = 1'($urandom);
      dev_en[i] = 1'($urandom);
      dev_data[i] = DW'($urandom);
    end
  endtask

  initial begin
    int guard;
    for (int i = 0; i < NREQ; i++) dev_data[i] = '0;

    #2 rstn = 1'b0;
    #1;
    check("rst_pad_t", 32'(pad_t), 32'd1);
    check("rst_pad_i", 32'(pad_i), 32'd1);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    repeat (6) @(negedge clk);
    check("idle_pad_t", 32'(pad_t), 32'd1);
    check("idle_pad_i", 32'(pad_i), 32'd1);
    check("idle_gnt", 32'(gnt), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Contention: all four writes, requester 0 sends A5.
    for (int i = 0; i < NREQ; i++) wdata[i*DW +: DW] = DW'($urandom);
    wdata[7:0] = 8'hA5;
    rd = '0;
    issue_batch(4'b1111);
    wait_batch(1'b0);
    randomise_slots();
    issue_batch(4'b1111);
    wait_batch(1'b0);

    // Read of 3C from requester 2's device.
    rd = '0;
    rd[2] = 1'b1;
    dev_en[2] = 1'b1;
    dev_data[2] = 8'h3C;
    issue_batch(4'b0100);
    wait_batch(1'b0);

    // Read with only the pull-up on the line.
    rd[1] = 1'b1;
    dev_en[1] = 1'b0;
    issue_batch(4'b0010);
    wait_batch(1'b0);

    // Abort during bit 3 of a write.
    rd = '0;
    req = 4'b0001;
    guard = 0;
    while (gnt == '0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("abort_granted", 32'(gnt), 32'b0001);
    repeat (13) @(negedge clk);
    check("abort_pre_drive", 32'(pad_t), 32'd0);
    #1 rstn = 1'b0;
    #1;
    check("abort_pad_t", 32'(pad_t), 32'd1);
    check("abort_pad_i", 32'(pad_i), 32'd1);
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rdata", 32'(rdata), 32'd0);
    req = '0;
    exp_q.delete();
    ptr_m = 0;
    last_rd = '0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    rstn = 1'b1;
    randomise_slots();
    issue_batch(4'b0110);
    wait_batch(1'b0);

    for (int n = 0; n < 20; n++) begin
      randomise_slots();
      issue_batch(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
      wait_batch(1'b1);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
